debounce_input: RTL and testbench

DEBOUNCE_INPUT -- requirements
Module: debounce_input

---
 rtl/debounce_input.sv | 108 ++++++++++
 tb/tb_debounce_input.sv | 134 +++++++++++++
 2 files changed

// File: rtl/debounce_input.sv
// debounce_input: synchronizes a bouncy asynchronous level and only passes a change once it is stable.
// Latency: CNT_MAX+2 clk edges from the first edge sampling a stable new raw_in to clean (CNT_MAX+1 without sync2).
// Backpressure: none; free-running level filter, busy marks a change that is still being qualified.
//
// Ports:
//   clk    in   1  sole clock, rising edge
//   rst    in   1  asynchronous, active-high reset
//   raw_in in   1  asynchronous bouncy level (button or switch)
//   clean  out  1  debounced clk-synchronous level (registered)
//   busy   out  1  high while a candidate change is being counted (cnt != 0)
//
// Build option: define DEBOUNCE_SYNC2_EN to add the second synchronizer flop (sync2).
// Without it the filter works directly on sync1 and latency drops by one edge.
// CNT_MAX legal range: 2..65535.
module debounce_input #(
  parameter int unsigned CNT_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic clean,
  output logic busy
);

  // Counter only has to reach CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
  localparam int unsigned CNT_W = ($clog2(CNT_MAX) == 0) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic sync1_d;
  logic sync1_q;
  logic stage;   // synchronized level seen by the qualification logic

  always_comb begin
    sync1_d = raw_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
    end
  end

`ifdef DEBOUNCE_SYNC2_EN
  logic sync2_d;
  logic sync2_q;

  always_comb begin
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync2_q <= 1'b0;
    end else begin
      sync2_q <= sync2_d;
    end
  end

  assign stage = sync2_q;
`else
  assign stage = sync1_q;
`endif

  // ---------------------------------------------------------------------------
  // Qualification counter and debounced level
  // ---------------------------------------------------------------------------
  logic             clean_d;
  logic             clean_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (stage == clean_q) begin
      // Input is back at (or still at) the clean level: drop any partial count.
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // CNT_MAX-th consecutive differing edge: accept the new level.
      // The >= (rather than ==) keeps cnt from ever wrapping.
      clean_d = stage;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  // Both outputs come straight from flops (busy is a decode of cnt_q only),
  // so neither can glitch on raw_in activity.
  assign clean = clean_q;
  assign busy  = (cnt_q != '0);

endmodule

// File: tb/tb_debounce_input.sv
// tb_debounce_input: directed scoreboard bench for debounce_input with CNT_MAX=4.
// Latency: expectations derived from the synchronizer depth selected by DEBOUNCE_SYNC2_EN.
// Backpressure: n/a.
module tb_debounce_input;

  localparam int C = 4;
`ifdef DEBOUNCE_SYNC2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic clean;
  logic busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];   // {clean, busy} expected after the next edge
  string      tag_q[$];

  always #5 clk = ~clk;

  debounce_input #(.CNT_MAX(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .clean  (clean),
    .busy   (busy)
  );

  task automatic check_now(input string tag, input logic e_clean, input logic e_busy);
    n_assert++;
    assert (clean === e_clean) else begin
      n_fail++;
      $error("FAIL %s clean: observed %b expected %b", tag, clean, e_clean);
    end
    n_assert++;
    assert (busy === e_busy) else begin
      n_fail++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, e_busy);
    end
  endtask

  // Drive raw_in for one clock, queue the expected outputs after that edge,
  // then pop and compare once the edge has happened.
  task automatic cyc(input string tag, input logic raw, input logic e_clean, input logic e_busy);
    logic [1:0] e;
    string      t;
    raw_in = raw;
    exp_q.push_back({e_clean, e_busy});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_now(t, e[1], e[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then idle low for 20 cycles.
    rst    = 1'b1;
    raw_in = 1'b0;
    #12;
    check_now("reset_hold", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc("idle_low", 1'b0, 1'b0, 1'b0);

    // Clean rising edge: clean changes on edge S+C, busy high on the C-1 edges before it.
    for (int k = 1; k <= S + C + 2; k++)
      cyc("rise", 1'b1, (k >= S + C), (k > S && k < S + C));

    // Falling with bounce 0,1,0,1 then stable 0: clean falls on the (S+C)-th edge
    // of the stable-low run; each bounce low sample only earns a single count.
    for (int k = 1; k <= 4 + S + C + 1; k++) begin
      int   m;
      logic r;
      logic eb;
      logic ec;
      m  = k - 4;
      r  = (k <= 4) ? logic'(k % 2 == 0) : 1'b0;
      eb = ((k - S) == 1) || ((k - S) == 3) || (k >= 5 && m > S && m < S + C);
      ec = !(k >= 5 && m >= S + C);
      cyc("bounce_fall", r, ec, eb);
    end

    // Glitch of C-1 high cycles is rejected; busy drops once the low level arrives.
    for (int i = 0; i < 3; i++) cyc("pre_glitch", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= S + C + 3; k++)
      cyc("glitch", (k <= C - 1), 1'b0, (k > S && k <= S + C - 1));
    for (int i = 0; i < 3; i++) cyc("post_glitch", 1'b0, 1'b0, 1'b0);

    // Reset asserted while cnt == 2: outputs clear without a clock edge.
    for (int k = 1; k <= S + 2; k++)
      cyc("rst_mid_pre", 1'b1, 1'b0, (k > S));
    #3;
    rst = 1'b1;
    #1;
    check_now("rst_async_mid", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("rst_held_mid", 1'b0, 1'b0);
    rst = 1'b0;
    // Qualification restarts from zero with raw_in still high.
    for (int k = 1; k <= S + C + 1; k++)
      cyc("post_rst_rise", 1'b1, (k >= S + C), (k > S && k < S + C));

    // Reset while clean is high: clean drops asynchronously.
    #3;
    rst = 1'b1;
    #1;
    check_now("rst_async_clean", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    raw_in = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 5; i++) cyc("post_rst_low", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
